// File: rtl/dlx_regfile_if.sv
// Decode/writeback-side bundle for the DLX register file: read ports, writeback,
// issue/flush scoreboard controls and the pending count.
interface dlx_regfile_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 3
);
  localparam int AW = $clog2(NREGS);

  // Strobe semantics: wb_en, iss_en and flush are single-cycle qualifiers sampled
  // at every posedge. There is no ready; the register file always accepts them.
  logic [NREAD*AW-1:0]    rs_addr;
  logic [NREAD*WIDTH-1:0] rs_data;
  logic [NREAD-1:0]       rs_busy;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [WIDTH-1:0]       wb_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_rd;
  logic                   flush;
  logic [AW:0]            npending;

  modport master (
    output rs_addr, wb_en, wb_addr, wb_data, iss_en, iss_rd, flush,
    input  rs_data, rs_busy, npending
  );

  modport slave (
    input  rs_addr, wb_en, wb_addr, wb_data, iss_en, iss_rd, flush,
    output rs_data, rs_busy, npending
  );
endinterface

// File: rtl/dlx_regfile.sv
// DLX register file: NREAD combinational read ports with writeback bypass, one
// write port, r0 hard-wired to zero, and a per-register pending-producer scoreboard.
module dlx_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 3
) (
  input  logic          clk,
  input  logic          reset,
  dlx_regfile_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0]       regs [NREGS];
  logic [NREGS-1:0]       pend;
  logic [NREGS-1:0]       pend_next;
  logic [AW:0]            npending_q;
  logic [AW:0]            npending_next;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic                   wb_live;

  // The bypass is suppressed while reset is held so every port reads zero.
  assign wb_live = bus.wb_en && !reset;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = bus.rs_addr[i*AW +: AW];
    assign hit  = wb_live && (bus.wb_addr == addr);

    assign rd_data[i*WIDTH +: WIDTH] = (addr == '0) ? '0 :
                                       hit          ? bus.wb_data :
                                                      regs[addr];
    assign rd_busy[i] = pend[addr] && !hit;
  end

  assign bus.rs_data  = rd_data;
  assign bus.rs_busy  = rd_busy;
  assign bus.npending = npending_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Issue outranks a same-cycle writeback: the new producer supersedes the old one.
  always_comb begin
    pend_next = pend;
    if (bus.flush) begin
      pend_next = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (bus.iss_en && (bus.iss_rd == AW'(r))) begin
          pend_next[r] = 1'b1;
        end else if (bus.wb_en && (bus.wb_addr == AW'(r))) begin
          pend_next[r] = 1'b0;
        end
      end
    end
    pend_next[0] = 1'b0;
  end

  always_comb begin
    npending_next = '0;
    for (int r = 1; r < NREGS; r++) begin
      npending_next = npending_next + (AW+1)'(pend_next[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      npending_q <= '0;
    end else begin
      pend       <= pend_next;
      npending_q <= npending_next;
    end
  end
endmodule

// File: tb/tb_dlx_regfile.sv
// Directed bench for dlx_regfile: storage, bypass, r0 rules, scoreboard lifecycle,
// flush and asynchronous reset, each step with hand-computed expectations.
module tb_dlx_regfile;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dlx_regfile_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  dlx_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.rs_data[p*WIDTH +: WIDTH];
  endfunction

  task automatic set_addr(input int p, input logic [4:0] a);
    bus.rs_addr[p*5 +: 5] = a;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic iss(input logic en, input logic [4:0] a);
    bus.iss_en = en;
    bus.iss_rd = a;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.rs_addr = '0;
    bus.flush   = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    iss(1'b0, 5'd0);

    // Reset state, including suppressed bypass while reset is held
    tick();
    tick();
    chk("rst_npending", 32'(bus.npending), 32'd0);
    set_addr(2, 5'd7);
    wb(1'b1, 5'd7, 32'hFFFF_0000);
    #1;
    chk("rst_bypass_off", rd(2), 32'h0);
    chk("rst_busy", 32'(bus.rs_busy), 32'd0);
    wb(1'b0, 5'd0, 32'h0);
    reset = 1'b0;

    // Basic write then read through storage
    tick();
    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    set_addr(0, 5'd5);
    set_addr(1, 5'd0);
    #1;
    chk("read_r5", rd(0), 32'hDEAD_BEEF);
    chk("read_r0", rd(1), 32'h0);

    // Write to r0 is ignored, and r0 wins over a bypass hit
    set_addr(0, 5'd0);
    wb(1'b1, 5'd0, 32'h0000_1234);
    #1;
    chk("r0_no_bypass", rd(0), 32'h0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("r0_after_wb", rd(0), 32'h0);

    // Same-cycle bypass on port 2
    set_addr(2, 5'd7);
    #1;
    chk("r7_before", rd(2), 32'h0);
    wb(1'b1, 5'd7, 32'hA5A5_A5A5);
    #1;
    chk("r7_bypass", rd(2), 32'hA5A5_A5A5);
    tick();
    wb(1'b0, 5'd0, 32'h0);

    // Scoreboard lifecycle on r3
    set_addr(0, 5'd3);
    iss(1'b1, 5'd3);
    #1;
    chk("r3_busy_issue_cycle", 32'(bus.rs_busy[0]), 32'd0);
    tick();
    iss(1'b0, 5'd0);
    #1;
    chk("r3_busy", 32'(bus.rs_busy[0]), 32'd1);
    chk("npend_1", 32'(bus.npending), 32'd1);
    wb(1'b1, 5'd3, 32'h3333_3333);
    #1;
    chk("r3_busy_hidden", 32'(bus.rs_busy[0]), 32'd0);
    chk("r3_fwd", rd(0), 32'h3333_3333);
    chk("npend_wb_cycle", 32'(bus.npending), 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("npend_0", 32'(bus.npending), 32'd0);
    chk("r3_busy_clear", 32'(bus.rs_busy[0]), 32'd0);
    chk("r3_stored", rd(0), 32'h3333_3333);

    // Issue and writeback to pending r9 in the same cycle: issue wins
    iss(1'b1, 5'd9);
    tick();
    iss(1'b0, 5'd0);
    set_addr(1, 5'd9);
    #1;
    chk("r9_pending", 32'(bus.rs_busy[1]), 32'd1);
    iss(1'b1, 5'd9);
    wb(1'b1, 5'd9, 32'h9999_9999);
    #1;
    chk("r9_busy_bypassed", 32'(bus.rs_busy[1]), 32'd0);
    tick();
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("r9_still_busy", 32'(bus.rs_busy[1]), 32'd1);
    chk("npend_iss_wb", 32'(bus.npending), 32'd1);
    chk("r9_data", rd(1), 32'h9999_9999);
    iss(1'b1, 5'd0);
    tick();
    iss(1'b0, 5'd0);
    set_addr(0, 5'd0);
    #1;
    chk("npend_iss_r0", 32'(bus.npending), 32'd1);
    chk("r0_never_busy", 32'(bus.rs_busy[0]), 32'd0);
    wb(1'b1, 5'd9, 32'h9999_9999);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("npend_r9_retired", 32'(bus.npending), 32'd0);

    // Flush discards pending producers but keeps the writeback data
    iss(1'b1, 5'd1);
    tick();
    iss(1'b1, 5'd2);
    tick();
    iss(1'b1, 5'd4);
    tick();
    iss(1'b0, 5'd0);
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    set_addr(2, 5'd4);
    #1;
    chk("npend_3", 32'(bus.npending), 32'd3);
    chk("busy_all", 32'(bus.rs_busy), 32'h7);
    bus.flush = 1'b1;
    iss(1'b1, 5'd6);
    wb(1'b1, 5'd10, 32'h1010_1010);
    #1;
    chk("busy_flush_cycle", 32'(bus.rs_busy), 32'h7);
    tick();
    bus.flush = 1'b0;
    iss(1'b0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("npend_flushed", 32'(bus.npending), 32'd0);
    chk("busy_flushed", 32'(bus.rs_busy), 32'h0);
    set_addr(0, 5'd6);
    set_addr(1, 5'd10);
    #1;
    chk("r6_not_busy", 32'(bus.rs_busy[0]), 32'd0);
    chk("r10_flush_wb", rd(1), 32'h1010_1010);

    // Asynchronous reset between clock edges
    iss(1'b1, 5'd11);
    tick();
    iss(1'b1, 5'd12);
    tick();
    iss(1'b0, 5'd0);
    set_addr(0, 5'd5);
    set_addr(1, 5'd11);
    #1;
    chk("pre_rst_r5", rd(0), 32'hDEAD_BEEF);
    chk("pre_rst_busy", 32'(bus.rs_busy[1]), 32'd1);
    chk("pre_rst_npend", 32'(bus.npending), 32'd2);
    reset = 1'b1;
    #1;
    chk("arst_data", rd(0), 32'h0);
    chk("arst_busy", 32'(bus.rs_busy), 32'h0);
    chk("arst_npend", 32'(bus.npending), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("post_rst_r5", rd(0), 32'h0);
    chk("post_rst_npend", 32'(bus.npending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dlx_regfile.md
# dlx_regfile

Parametrised register file with bypass and scoreboard for the pipelined DLX core, sitting between decode and writeback. It provides NREAD combinational read ports and one write port, with register 0 hard-wired to zero. Writeback-to-read forwarding is built in. A per-register pending bit tracks in-flight producers so decode can detect RAW hazards and stall.

## Interface
- WIDTH, 32, data width of each register
- NREGS, 32, number of registers; power of two, ≥ 2; AW = $clog2(NREGS)
- NREAD, 3, number of read ports, ≥ 1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and scoreboard state
- rs_addr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
- rs_data  out  NREAD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH]
- rs_busy  out  NREAD  port i's source register has a pending producer
- wb_en  in  1  writeback strobe
- wb_addr  in  AW  writeback destination
- wb_data  in  WIDTH  writeback value
- iss_en  in  1  an instruction with a destination issues this cycle
- iss_rd  in  AW  destination of the issuing instruction
- flush  in  1  discard all pending producers (branch/exception squash)
- npending  out  AW+1  registered count of set pending bits

## Operation
- Storage: NREGS×WIDTH registers plus NREGS pending bits and the npending counter.
- Register 0:
  - Always reads 0 and is never busy.
  - wb_en to address 0 is ignored.
  - iss_en to address 0 is ignored: no pending bit is set and npending does not change.
- Read port i, combinational, evaluated in priority order:
  - rs_addr_i == 0 → rs_data_i = 0.
  - Otherwise, if wb_en and wb_addr == rs_addr_i → rs_data_i = wb_data (bypass).
  - Otherwise → rs_data_i = regs[rs_addr_i].
- rs_busy_i = pend[rs_addr_i] AND NOT (wb_en AND wb_addr == rs_addr_i). A same-cycle writeback hides the busy bit, because the bypassed value is valid.
- Write: at posedge, if wb_en and wb_addr != 0, then regs[wb_addr] <= wb_data.
- Scoreboard update at posedge, for register r ≠ 0, in priority order:
  - flush → pend[r] <= 0 for all r; iss_en and wb_en pending effects are discarded. The wb data write itself still occurs.
  - iss_en and iss_rd == r → pend[r] <= 1. Issue wins over a same-cycle writeback to r, because the new producer supersedes the old one.
  - wb_en and wb_addr == r → pend[r] <= 0.
  - Otherwise → pend[r] is held.
- Issue to an already-pending register keeps the bit at 1; npending is unchanged. A single bit per register is sufficient because the pipeline does not issue a second writer of r until the first retires or is flushed.
- Writeback to a non-pending register still writes data; pend stays 0.
- npending:
  - Next value = number of set bits in the next pend vector.
  - Range 0..NREGS-1; it can never reach NREGS because register 0 is excluded.

## Timing
- Reads, forwarding and rs_busy are combinational from the address and wb inputs, with zero cycles of latency.
- A write is visible through storage from the cycle after wb_en; in the same cycle it is visible only via the bypass.
- A pending bit set by iss_en is visible on rs_busy the cycle after issue.
- A pending bit cleared by writeback is hidden in the writeback cycle via the bypass rule, and stored as 0 from the next cycle.
- flush takes effect at the next posedge; rs_busy in the flush cycle still reflects the old pend.
- While reset is asserted:
  - all registers read 0 and pend = 0;
  - rs_data = 0 and rs_busy = 0 for every port; the bypass is suppressed;
  - npending = 0.
- Reset asserted mid-operation immediately clears the state without waiting for a clock edge.
- After deassertion, the first posedge accepts wb_en and iss_en normally.

## Test plan
- Reset then basic write/read:
  - wb_en, r5 ← 0xDEADBEEF; next cycle rs_addr0 = 5 → rs_data0 = 0xDEADBEEF.
  - rs_addr1 = 0 → rs_data1 = 0.
  - wb to r0 with 0x1234 → r0 still reads 0.
- Bypass: in one cycle, wb r7 ← 0xA5A5A5A5 and rs_addr2 = 7 → rs_data2 = 0xA5A5A5A5 in that same cycle; r7 previously held 0.
- Scoreboard lifecycle:
  - iss_en r3 → next cycle rs_busy = 1 and npending = 1.
  - wb r3 cycle → rs_busy = 0 combinationally and data is forwarded; next cycle npending = 0.
- Simultaneous issue and writeback to r9 while r9 is pending → r9 stays pending and npending is unchanged. The same with iss_rd = 0 → npending is unchanged.
- Flush: issue r1, r2, r4 (npending = 3), then flush together with iss_en r6 → next cycle npending = 0 and all busy bits are clear. A wb in the flush cycle still writes its data.
- Async reset mid-run: with r5 = 0xDEADBEEF and npending = 2, pulse reset between clock edges → rs_data = 0, rs_busy = 0 and npending = 0 immediately. After release, reading r5 returns 0.
